// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit
// Registered two-operand bitwise unit with a valid/ready handshake on both
// sides. A transaction is either a single plain beat or a multi-beat
// reduction that folds a stream of operands into one accumulator value.
// Each result carries zero/all-ones flags and a saturating beat count.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first beat of a transaction
// ACCUM | reduction in progress; acc_reg holds the partial result
module bitwise_logic_unit #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             last,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] beats
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc_reg, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_q, op_nxt;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] load_beats;
    logic [WIDTH-1:0] f_first;
    logic [WIDTH-1:0] f_fold;

    function automatic logic [WIDTH-1:0] bit_fn(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Accept whenever the output slot is free or being drained this cycle;
    // reset forces ready low so nothing is taken while rst_n is asserted.
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // First beat uses the live op and both operands; later beats fold i0
    // into the accumulator using the op captured at the start.
    assign f_first = bit_fn(op, i0, i1);
    assign f_fold  = bit_fn(op_q, acc_reg, i0);

    // State, accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_reg <= '0;
            cnt     <= '0;
            op_q    <= 3'b000;
        end else begin
            state   <= state_nxt;
            acc_reg <= acc_nxt;
            cnt     <= cnt_nxt;
            op_q    <= op_nxt;
        end
    end

    // Next-state logic and output-register load request.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc_reg;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        load       = 1'b0;
        load_val   = '0;
        load_beats = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc && !last) begin
                        op_nxt    = op;
                        acc_nxt   = f_first;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ACCUM;
                    end else begin
                        // Plain op and single-beat reduction are the same thing.
                        load       = 1'b1;
                        load_val   = f_first;
                        load_beats = CNT_ONE;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = f_fold;
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    if (last) begin
                        load       = 1'b1;
                        load_val   = f_fold;
                        load_beats = cnt_nxt;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: a load wins over a drain in the same cycle, and the
    // flags are derived from the loaded value so they stay aligned with s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            beats     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            s         <= load_val;
            zero      <= (load_val == '0);
            ones      <= (load_val == ALL_ONES);
            beats     <= load_beats;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit. Two instances share all inputs:
// the default CNT_W=8 unit and a CNT_W=2 unit used for beat saturation.
module tb_bitwise_logic_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [2:0]  op;
    logic        acc;
    logic        last;
    logic [19:0] i0;
    logic [19:0] i1;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [19:0] s;
    logic [19:0] s2;
    logic        zero;
    logic        zero2;
    logic        ones;
    logic        ones2;
    logic [7:0]  beats;
    logic [1:0]  beats2;

    int total = 0;
    int bad   = 0;

    bitwise_logic_unit #(.WIDTH(20), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc(acc), .last(last), .i0(i0), .i1(i1),
        .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .zero(zero), .ones(ones), .beats(beats)
    );

    bitwise_logic_unit #(.WIDTH(20), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .acc(acc), .last(last), .i0(i0), .i1(i1),
        .out_valid(out_valid2), .out_ready(out_ready), .s(s2),
        .zero(zero2), .ones(ones2), .beats(beats2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one beat across one rising edge, then drop in_valid.
    task automatic beat(input logic [2:0] o, input logic a, input logic l,
                        input logic [19:0] x, input logic [19:0] y);
        op = o; acc = a; last = l; i0 = x; i1 = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        op = 3'b001; acc = 1'b0; last = 1'b0; i0 = 20'h0005F; i1 = 20'h0;

        // reset held two cycles with a beat offered
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_s",         32'(s),         32'h0);
        chk("rst_beats",     32'(beats),     32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_zero",      32'(zero),      32'h0);
        in_valid = 1'b0;
        rst_n = 1'b1; #1;
        chk("rel_in_ready",  32'(in_ready),  32'h1);

        // plain ops, back-to-back
        beat(3'b001, 1'b0, 1'b0, 20'h0005F, 20'h00000);
        chk("or_s",      32'(s),         32'h0005F);
        chk("or_valid",  32'(out_valid), 32'h1);
        chk("or_beats",  32'(beats),     32'h1);
        beat(3'b000, 1'b0, 1'b0, 20'hC0003, 20'hC0003);
        chk("and_s",     32'(s),         32'hC0003);
        beat(3'b010, 1'b0, 1'b0, 20'hFFFFF, 20'hFFFFF);
        chk("xor_s",     32'(s),         32'h0);
        chk("xor_zero",  32'(zero),      32'h1);
        chk("xor_ones",  32'(ones),      32'h0);
        beat(3'b011, 1'b0, 1'b0, 20'h00000, 20'h00000);
        chk("nor_s",     32'(s),         32'hFFFFF);
        chk("nor_ones",  32'(ones),      32'h1);
        chk("nor_zero",  32'(zero),      32'h0);
        beat(3'b110, 1'b0, 1'b0, 20'hF0F0F, 20'h0FF00);
        chk("andn_s",    32'(s),         32'hF000F);

        // OR reduction; op and acc changed mid-stream must be ignored
        beat(3'b001, 1'b1, 1'b0, 20'h00001, 20'h00002);
        chk("red1_valid", 32'(out_valid), 32'h0);
        beat(3'b000, 1'b0, 1'b0, 20'h00010, 20'hFFFFF);
        chk("red2_valid", 32'(out_valid), 32'h0);
        beat(3'b010, 1'b0, 1'b1, 20'h80000, 20'h00000);
        chk("red_s",      32'(s),         32'h80013);
        chk("red_beats",  32'(beats),     32'h3);
        chk("red_valid",  32'(out_valid), 32'h1);

        // back-pressure with a beat waiting
        out_ready = 1'b0; #1;
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        op = 3'b111; acc = 1'b0; last = 1'b0; i0 = 20'hABCDE; i1 = 20'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_s_hold",  32'(s),         32'h80013);
            chk("bp_beats",   32'(beats),     32'h3);
            chk("bp_valid",   32'(out_valid), 32'h1);
        end
        out_ready = 1'b1; #1;
        chk("bp_rel_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_s",     32'(s),         32'hABCDE);
        chk("bp_new_valid", 32'(out_valid), 32'h1);
        chk("bp_new_beats", 32'(beats),     32'h1);
        @(posedge clk); #1;
        chk("drain_valid",  32'(out_valid), 32'h0);

        // 5-beat AND reduction: CNT_W=2 saturates at 3
        beat(3'b000, 1'b1, 1'b0, 20'hFFFFF, 20'hFFFFF);
        for (int k = 0; k < 3; k++) beat(3'b001, 1'b0, 1'b0, 20'hFFFFF, 20'h0);
        beat(3'b001, 1'b0, 1'b1, 20'hFFFFF, 20'h0);
        chk("sat_s",      32'(s2),     32'hFFFFF);
        chk("sat_ones",   32'(ones2),  32'h1);
        chk("sat_beats",  32'(beats2), 32'h3);
        chk("wide_beats", 32'(beats),  32'h5);
        chk("wide_s",     32'(s),      32'hFFFFF);

        // reset in the middle of a reduction
        beat(3'b001, 1'b1, 1'b0, 20'h00111, 20'h00222);
        beat(3'b001, 1'b0, 1'b0, 20'h00444, 20'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        beat(3'b111, 1'b0, 1'b0, 20'h12345, 20'h0);
        chk("post_rst_s",     32'(s),         32'h12345);
        chk("post_rst_beats", 32'(beats),     32'h1);
        chk("post_rst_valid2", 32'(out_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit for the CPU datapath: successor to the fixed 20-bit OR block. Computes any of eight two-operand bitwise functions on WIDTH-bit operands with a valid/ready handshake on both sides and one output register stage. Also supports a multi-beat reduction mode that folds a stream of operands into one result, for mask building and flag aggregation. Status flags (zero, all-ones) and a beat count accompany each result.

## Interface
- WIDTH, 20, operand/result width (≥1)
- CNT_W, 8, width of beat counter
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset: synchronous, active-low
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit accepts beat this cycle
- op  input  3  function select (sampled on first beat of a transaction)
- acc  input  1  1 = start reduction transaction (sampled in IDLE only)
- last  input  1  final beat of reduction (ignored for plain beats)
- i0  input  WIDTH  operand A
- i1  input  WIDTH  operand B (first beat only in reduction)
- out_valid  output  1  result held in output register
- out_ready  input  1  consumer takes result
- s  output  WIDTH  result
- zero  output  1  s == 0
- ones  output  1  s == all ones
- beats  output  CNT_W  beats folded into s, saturating at 2^CNT_W−1

## Operation
- op encoding f(a,b): 000 a&b, 001 a|b, 010 a^b, 011 ~(a|b), 100 ~(a&b), 101 ~(a^b), 110 a&~b, 111 a.
- Beat accepted when in_valid && in_ready. in_ready = rst_n && (!out_valid || out_ready).
- FSM states IDLE, ACCUM.
- IDLE, accepted beat, acc=0: plain op; output register loads s=f(i0,i1), beats=1, out_valid=1. Stay IDLE.
- IDLE, accepted beat, acc=1, last=0: latch op into op_q; acc_reg=f(i0,i1); cnt=1; → ACCUM. No output.
- IDLE, accepted beat, acc=1, last=1: single-beat reduction, identical to plain op (beats=1). Stay IDLE.
- ACCUM, accepted beat: acc_reg=f_op_q(acc_reg,i0); i1, op, acc ignored; cnt=sat(cnt+1). If last=1: output register loads s=new acc_reg, beats=new cnt, out_valid=1, → IDLE.
- In ACCUM with output register still full and not drained, in_ready=0 (uniform rule); reduction stalls, state kept.
- Output register holds s/zero/ones/beats stable while out_valid && !out_ready.
- out_valid clears when out_ready && out_valid and no new result loads the same cycle; simultaneous drain and load → new result, out_valid stays 1.
- zero/ones computed from value loaded into s, registered with it.
- beats saturates; never wraps.

## Timing
- Reset (rst_n=0 at clock edge): state=IDLE, out_valid=0, s=0, zero=0, ones=0, beats=0, acc_reg=0, cnt=0, op_q=000. in_ready=0 while rst_n=0.
- Reset mid-reduction discards partial accumulator; no output emitted.
- Plain op latency: result visible with out_valid=1 the cycle after acceptance.
- Reduction: result visible the cycle after the last beat is accepted; N-beat reduction with no stalls occupies N consecutive cycles.
- Full throughput: one plain op per cycle when out_ready held 1.
- Output back-pressure: in_ready deasserts combinationally same cycle out_valid=1 && out_ready=0.
- No combinational path from i0/i1/op to outputs; only in_ready depends combinationally on out_ready.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 → out_valid=0, s=0, beats=0, in_ready=0; release → in_ready=1.
- Plain ops, WIDTH=20, out_ready=1: op=001 i0=0x0005F i1=0x00000 → s=0x0005F next cycle; op=000 i0=i1=0xC0003 → s=0xC0003; op=010 i0=i1=0xFFFFF → s=0, zero=1; op=011 i0=i1=0 → s=0xFFFFF, ones=1.
- OR reduction: acc=1 op=001 (i0=0x00001,i1=0x00002), then 0x00010, then 0x80000 last=1 → s=0x80013, beats=3, op input changed mid-stream has no effect.
- Back-pressure: out_ready=0 with result pending → in_ready=0, s stable multiple cycles; out_ready=1 with new beat same cycle → new result loads, out_valid remains 1, no beat lost.
- Saturation with CNT_W=2: 5-beat AND reduction of 0xFFFFF → s=0xFFFFF, ones=1, beats=3.
- Reset mid-reduction after 2 beats, then plain op=111 i0=0x12345 → s=0x12345, beats=1, no stale accumulator output.
